wsa_result_deskew: RTL

WSA_RESULT_DESKEW -- requirements
Module: wsa_result_deskew

---
 rtl/wsa_result_deskew_pkg.sv | 27 ++
 rtl/wsa_row_fifo.sv | 61 ++++++
 rtl/wsa_result_deskew.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wsa_result_deskew_pkg.sv
// ----------------------------------------------------------------------------
// wsa_result_deskew_pkg: shared widths, defaults and FSM encoding (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package wsa_result_deskew_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_M     = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_K     = 16;

  // Partial accumulator width: full product plus growth over K additions.
  function automatic int acc_width(input int width, input int k);
    return 2 * width + $clog2(k);
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wsa_row_fifo.sv
// ----------------------------------------------------------------------------
// wsa_row_fifo: synchronous row FIFO with registered storage and flags (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module wsa_row_fifo
  import wsa_result_deskew_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr && !clr) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wsa_result_deskew.sv
// ----------------------------------------------------------------------------
// wsa_result_deskew: sums partial pairs, realigns staggered columns into rows,
// tags them with a row index and queues them for the consumer (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module wsa_result_deskew
  import wsa_result_deskew_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int ACC_W = acc_width(DEF_WIDTH, DEF_K),
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clc,
  input  logic [N-1:0]           in_valid,
  input  logic [2*ACC_W*N-1:0]   in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W*N-1:0]     out_data,
  output logic [$clog2(M):0]     out_row,
  output logic                   out_last,
  output logic                   tile_done,
  output logic                   ovf,
  output logic                   err
);

  localparam int ROW_W  = $clog2(M) + 1;
  localparam int FIFO_W = ROW_W + ACC_W * N;

  logic [N-1:0][ACC_W-1:0] s1_sum;
  logic [N-1:0]            s1_vld;
  logic [N-1:0][ACC_W-1:0] dly_sum;
  logic [N-1:0]            dly_vld;
  logic                    al_vld;
  logic                    al_bad;
  logic [ACC_W*N-1:0]      al_data;
  state_t                  state_q;
  state_t                  state_d;
  logic [ROW_W-1:0]        row_cnt;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    do_push;
  logic                    ovf_evt;
  logic                    err_evt;
  logic                    done_evt;
  logic [FIFO_W-1:0]       fifo_rdata;

  // Stage 1: pairwise sum, wrapping modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s1_vld <= '0;
    else if (clc) s1_vld <= '0;
    else          s1_vld <= in_valid;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      s1_sum[j] <= in_result[2*j*ACC_W +: ACC_W] + in_result[(2*j+1)*ACC_W +: ACC_W];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign dly_sum[j] = s1_sum[j];
      assign dly_vld[j] = s1_vld[j];
    end else begin : g_delay
      logic [ACC_W-1:0] sr_sum [D];
      logic [D-1:0]     sr_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_vld <= '0;
        end else if (clc) begin
          sr_vld <= '0;
        end else begin
          sr_vld[0] <= s1_vld[j];
          for (int k = 1; k < D; k++) sr_vld[k] <= sr_vld[k-1];
        end
      end

      always_ff @(posedge clk) begin
        sr_sum[0] <= s1_sum[j];
        for (int k = 1; k < D; k++) sr_sum[k] <= sr_sum[k-1];
      end

      assign dly_sum[j] = sr_sum[D-1];
      assign dly_vld[j] = sr_vld[D-1];
    end
  end

  // Column N-1 is the row timing reference; a missing earlier column is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_vld <= 1'b0;
      al_bad <= 1'b0;
    end else if (clc) begin
      al_vld <= 1'b0;
      al_bad <= 1'b0;
    end else begin
      al_vld <= dly_vld[N-1];
      al_bad <= dly_vld[N-1] & ~(&dly_vld);
    end
  end

  always_ff @(posedge clk) begin
    al_data <= dly_sum;
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_push  = 1'b0;
    ovf_evt  = 1'b0;
    err_evt  = al_vld && al_bad;
    done_evt = 1'b0;
    if (al_vld) begin
      if (state_q == DONE) begin
        err_evt = 1'b1;
      end else if (full && !pop) begin
        ovf_evt = 1'b1;
      end else begin
        do_push = 1'b1;
        if (row_cnt == ROW_W'(M - 1)) begin
          done_evt = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = COLLECT;
        end
      end
    end
    if (clc) begin
      state_d  = IDLE;
      do_push  = 1'b0;
      ovf_evt  = 1'b0;
      err_evt  = 1'b0;
      done_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      tile_done <= 1'b0;
    end else if (clc) begin
      row_cnt   <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      if (do_push) row_cnt <= row_cnt + ROW_W'(1);
      if (ovf_evt) ovf <= 1'b1;
      if (err_evt) err <= 1'b1;
      tile_done <= done_evt;
    end
  end

  wsa_row_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clc),
    .push  (do_push),
    .wdata ({row_cnt, al_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_data = fifo_rdata[ACC_W*N-1:0];
  assign out_row  = fifo_rdata[FIFO_W-1 -: ROW_W];
  assign out_last = out_valid && (out_row == ROW_W'(M - 1));

endmodule

`default_nettype wire
